// File: rtl/pc_seq_ctrl.sv
// Next-PC sequencer: picks sequential / branch / trap source for the PC register,
// buffers one redirect seen during a stall and replaces illegal targets with TRAP_VEC.
module pc_seq_ctrl #(
  parameter int                XLEN         = 32,
  parameter logic [XLEN-1:0]   BOOT_ADDR    = 32'h0000_0000,
  parameter int                IT_RAM_DEPTH = 4096,
  parameter logic [XLEN-1:0]   TRAP_VEC     = 32'h0000_0040
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] pc_addr,
  input  logic            stall,
  input  logic            br_valid,
  input  logic [XLEN-1:0] br_target,
  input  logic            trap_valid,
  input  logic [XLEN-1:0] trap_target,
  output logic            pc_write_en,
  output logic [XLEN-1:0] pc_write_addr,
  output logic            flush,
  output logic            fetch_valid,
  output logic            fetch_fault
);

  localparam logic [XLEN-1:0] DEPTH_W = XLEN'(IT_RAM_DEPTH);
  localparam logic [XLEN-1:0] LIMIT   = BOOT_ADDR + DEPTH_W;
  localparam logic [XLEN-1:0] STEP    = XLEN'(4);

  typedef enum logic [1:0] {BOOT, RUN, HOLD} state_t;

  state_t          state, state_d;
  logic            pend_valid, pend_valid_d;
  logic            pend_trap, pend_trap_d;
  logic [XLEN-1:0] pend_target, pend_target_d;

  logic            live_valid;
  logic            live_wins;
  logic            sel_valid;
  logic            sel_trap;
  logic [XLEN-1:0] sel_target;
  logic [XLEN-1:0] seq_addr;

  // Offset form of the range check avoids a constant compare when BOOT_ADDR is 0.
  function automatic logic is_illegal(input logic [XLEN-1:0] t);
    return (t[1:0] != 2'b00) || ((t - BOOT_ADDR) >= DEPTH_W);
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= BOOT;
      pend_valid  <= 1'b0;
      pend_trap   <= 1'b0;
      pend_target <= '0;
    end else begin
      state       <= state_d;
      pend_valid  <= pend_valid_d;
      pend_trap   <= pend_trap_d;
      pend_target <= pend_target_d;
    end
  end

  // Live request beats the buffered one unless that would let a branch displace a trap.
  always_comb begin
    live_valid = trap_valid | br_valid;
    live_wins  = live_valid && (trap_valid || !pend_valid || !pend_trap);
    sel_valid  = live_valid | pend_valid;
    sel_trap   = live_wins ? trap_valid : pend_trap;
    if (live_wins) sel_target = trap_valid ? trap_target : br_target;
    else           sel_target = pend_target;
    seq_addr = pc_addr + STEP;
    if (seq_addr >= LIMIT) seq_addr = BOOT_ADDR;
  end

  always_comb begin
    state_d       = state;
    pend_valid_d  = pend_valid;
    pend_trap_d   = pend_trap;
    pend_target_d = pend_target;
    pc_write_en   = 1'b0;
    pc_write_addr = '0;
    flush         = 1'b0;
    fetch_valid   = 1'b0;
    fetch_fault   = 1'b0;

    case (state)
      BOOT: begin
        pc_write_en   = 1'b1;
        pc_write_addr = BOOT_ADDR;
        state_d       = RUN;
      end
      RUN, HOLD: begin
        fetch_valid = (state == RUN);
        if (stall) begin
          state_d       = HOLD;
          pend_valid_d  = sel_valid;
          pend_trap_d   = sel_trap;
          pend_target_d = sel_target;
        end else begin
          state_d       = RUN;
          pc_write_en   = 1'b1;
          pend_valid_d  = 1'b0;
          pend_trap_d   = 1'b0;
          pend_target_d = '0;
          if (sel_valid) begin
            flush = 1'b1;
            if (is_illegal(sel_target)) begin
              pc_write_addr = TRAP_VEC;
              fetch_fault   = 1'b1;
            end else begin
              pc_write_addr = sel_target;
            end
          end else begin
            pc_write_addr = seq_addr;
          end
        end
      end
      default: state_d = BOOT;
    endcase

    if (rst) begin
      pc_write_en   = 1'b0;
      pc_write_addr = '0;
      flush         = 1'b0;
      fetch_valid   = 1'b0;
      fetch_fault   = 1'b0;
    end
  end

endmodule

// File: tb/tb_pc_seq_ctrl.sv
// Directed bench for pc_seq_ctrl: driver pushes hand-computed expected outputs per cycle,
// a monitor pops and compares them each cycle at the falling edge.
module tb_pc_seq_ctrl;

  localparam int W = 36;  // {we, flush, fetch_valid, fault, addr[31:0]}

  logic        clk;
  logic        rst;
  logic [31:0] pc_addr;
  logic        stall;
  logic        br_valid;
  logic [31:0] br_target;
  logic        trap_valid;
  logic [31:0] trap_target;
  logic        pc_write_en;
  logic [31:0] pc_write_addr;
  logic        flush;
  logic        fetch_valid;
  logic        fetch_fault;

  logic [W-1:0] exp_q[$];
  int compared   = 0;
  int mismatched = 0;
  int cyc        = 0;

  pc_seq_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .pc_addr      (pc_addr),
    .stall        (stall),
    .br_valid     (br_valid),
    .br_target    (br_target),
    .trap_valid   (trap_valid),
    .trap_target  (trap_target),
    .pc_write_en  (pc_write_en),
    .pc_write_addr(pc_write_addr),
    .flush        (flush),
    .fetch_valid  (fetch_valid),
    .fetch_fault  (fetch_fault)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // driver: apply one cycle of inputs just after the rising edge and push its expectation
  task automatic step(input logic r, input logic st,
                      input logic bv, input logic [31:0] bt,
                      input logic tv, input logic [31:0] tt,
                      input logic [31:0] pc,
                      input logic ewe, input logic [31:0] eaddr,
                      input logic efl, input logic efv, input logic eft);
    @(posedge clk);
    #1;
    rst = r; stall = st; br_valid = bv; br_target = bt;
    trap_valid = tv; trap_target = tt; pc_addr = pc;
    exp_q.push_back({ewe, efl, efv, eft, eaddr});
  endtask

  // monitor / scoreboard
  always @(negedge clk) begin
    logic [W-1:0] e;
    logic [W-1:0] a;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a = {pc_write_en, flush, fetch_valid, fetch_fault, pc_write_addr};
      if (!e[35]) a[31:0] = e[31:0];  // address is don't-care when no write
      compared++;
      if (a !== e) begin
        mismatched++;
        $display("FAIL cyc%0d outputs: got we=%b fl=%b fv=%b ft=%b addr=%h, want we=%b fl=%b fv=%b ft=%b addr=%h",
                 cyc, a[35], a[34], a[33], a[32], a[31:0], e[35], e[34], e[33], e[32], e[31:0]);
      end
      cyc++;
    end
  end

  initial begin
    rst = 1'b1; stall = 1'b0; br_valid = 1'b0; br_target = '0;
    trap_valid = 1'b0; trap_target = '0; pc_addr = '0;

    //   rst st bv bt        tv tt          pc           we addr         fl fv ft
    // reset, boot, sequential
    step(1, 0, 0, 0,        0, 0,          32'h0,       0, 32'h0,       0, 0, 0);
    step(1, 0, 0, 0,        0, 0,          32'h0,       0, 32'h0,       0, 0, 0);
    step(0, 0, 0, 0,        0, 0,          32'h0,       1, 32'h0,       0, 0, 0);
    step(0, 0, 0, 0,        0, 0,          32'h0,       1, 32'h4,       0, 1, 0);
    step(0, 0, 0, 0,        0, 0,          32'h4,       1, 32'h8,       0, 1, 0);
    step(0, 0, 0, 0,        0, 0,          32'h8,       1, 32'hC,       0, 1, 0);
    // branch, then trap beats branch in the same cycle
    step(0, 0, 1, 32'h200,  0, 0,          32'h100,     1, 32'h200,     1, 1, 0);
    step(0, 0, 1, 32'h200,  1, 32'h80,     32'h100,     1, 32'h80,      1, 1, 0);
    // 3-cycle stall: branch then trap buffered, trap applied on release
    step(0, 1, 1, 32'h300,  0, 0,          32'h80,      0, 32'h0,       0, 1, 0);
    step(0, 1, 0, 0,        1, 32'h80,     32'h80,      0, 32'h0,       0, 0, 0);
    step(0, 1, 0, 0,        0, 0,          32'h80,      0, 32'h0,       0, 0, 0);
    step(0, 0, 0, 0,        0, 0,          32'h80,      1, 32'h80,      1, 0, 0);
    step(0, 0, 0, 0,        0, 0,          32'h80,      1, 32'h84,      0, 1, 0);
    // illegal targets: misaligned, at the limit, misaligned trap
    step(0, 0, 1, 32'h202,  0, 0,          32'h84,      1, 32'h40,      1, 1, 1);
    step(0, 0, 0, 0,        0, 0,          32'h40,      1, 32'h44,      0, 1, 0);
    step(0, 0, 1, 32'h1000, 0, 0,          32'h44,      1, 32'h40,      1, 1, 1);
    step(0, 0, 0, 0,        1, 32'h1,      32'h40,      1, 32'h40,      1, 1, 1);
    // top-of-RAM wrap
    step(0, 0, 0, 0,        0, 0,          32'hFFC,     1, 32'h0,       0, 1, 0);
    // newer branch overwrites older pending branch
    step(0, 1, 1, 32'h300,  0, 0,          32'h0,       0, 32'h0,       0, 1, 0);
    step(0, 1, 1, 32'h400,  0, 0,          32'h0,       0, 32'h0,       0, 0, 0);
    step(0, 0, 0, 0,        0, 0,          32'h0,       1, 32'h400,     1, 0, 0);
    step(0, 0, 0, 0,        0, 0,          32'h400,     1, 32'h404,     0, 1, 0);
    // branch never overwrites pending trap
    step(0, 1, 0, 0,        1, 32'h100,    32'h404,     0, 32'h0,       0, 1, 0);
    step(0, 1, 1, 32'h300,  0, 0,          32'h404,     0, 32'h0,       0, 0, 0);
    step(0, 0, 0, 0,        0, 0,          32'h404,     1, 32'h100,     1, 0, 0);
    // live branch at release beats older pending branch
    step(0, 1, 1, 32'h300,  0, 0,          32'h100,     0, 32'h0,       0, 1, 0);
    step(0, 0, 1, 32'h600,  0, 0,          32'h100,     1, 32'h600,     1, 0, 0);
    // live illegal trap at release beats pending branch and faults
    step(0, 1, 1, 32'h300,  0, 0,          32'h600,     0, 32'h0,       0, 1, 0);
    step(0, 0, 0, 0,        1, 32'hFFF0,   32'h600,     1, 32'h40,      1, 0, 1);
    // reset while holding a pending branch
    step(0, 1, 1, 32'h300,  0, 0,          32'h10,      0, 32'h0,       0, 1, 0);
    step(1, 0, 0, 0,        0, 0,          32'h10,      0, 32'h0,       0, 0, 0);
    step(0, 0, 0, 0,        0, 0,          32'h10,      1, 32'h0,       0, 0, 0);
    step(0, 0, 0, 0,        0, 0,          32'h0,       1, 32'h4,       0, 1, 0);
    step(0, 0, 0, 0,        0, 0,          32'h4,       1, 32'h8,       0, 1, 0);

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
    #1;
    if (exp_q.size() > 0) begin
      mismatched++;
      $display("FAIL drain: got %0d entries left, want 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
